// File: rtl/mips_control_sequencer.sv
// mips_control_sequencer: multi-cycle control FSM that latches one instruction
// and steps the MIPS datapath through DECODE/EXEC/MEM/WB with registered controls.
`default_nettype none

module mips_control_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        inst_in,
  input  logic               inst_valid,
  output logic               inst_ready,
  output logic [31:0]        Inst,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic [2:0]         ALUctrl,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               MemToReg,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
  } ctrl_t;

  state_t state;
  ctrl_t  ctrl;
  logic   is_lw;
  logic   is_sw;

  logic       d_legal;
  logic       d_reg_dst;
  logic       d_alu_src;
  logic       d_mem_to_reg;
  logic       d_lw;
  logic       d_sw;
  logic [2:0] d_alu;

  // Decode straight from the instruction register; only consumed in DECODE.
  always_comb begin
    d_legal      = 1'b0;
    d_reg_dst    = 1'b0;
    d_alu_src    = 1'b0;
    d_mem_to_reg = 1'b0;
    d_lw         = 1'b0;
    d_sw         = 1'b0;
    d_alu        = 3'b010;
    case (Inst[31:26])
      6'h00: begin
        d_reg_dst = 1'b1;
        d_legal   = 1'b1;
        case (Inst[5:0])
          6'h20:   d_alu = 3'b010;
          6'h22:   d_alu = 3'b110;
          6'h24:   d_alu = 3'b000;
          6'h25:   d_alu = 3'b001;
          6'h2A:   d_alu = 3'b111;
          default: d_legal = 1'b0;
        endcase
      end
      6'h08: begin
        d_alu_src = 1'b1;
        d_legal   = 1'b1;
      end
      6'h23: begin
        d_alu_src    = 1'b1;
        d_mem_to_reg = 1'b1;
        d_lw         = 1'b1;
        d_legal      = 1'b1;
      end
      6'h2B: begin
        d_alu_src = 1'b1;
        d_sw      = 1'b1;
        d_legal   = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      Inst        <= '0;
      ctrl        <= '0;
      is_lw       <= 1'b0;
      is_sw       <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid) begin
            Inst  <= inst_in;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!d_legal) begin
            state   <= IDLE;
            done    <= 1'b1;
            illegal <= 1'b1;
          end else begin
            ctrl.reg_dst    <= d_reg_dst;
            ctrl.alu_src    <= d_alu_src;
            ctrl.alu_ctrl   <= d_alu;
            ctrl.mem_to_reg <= d_mem_to_reg;
            is_lw           <= d_lw;
            is_sw           <= d_sw;
            state           <= EXEC;
          end
        end
        EXEC: begin
          if (is_lw) begin
            ctrl.mem_read <= 1'b1;
            state         <= MEM;
          end else if (is_sw) begin
            ctrl.mem_write <= 1'b1;
            state          <= MEM;
          end else begin
            ctrl.reg_write <= 1'b1;
            state          <= WB;
          end
        end
        MEM: begin
          if (is_lw) begin
            ctrl.reg_write <= 1'b1;
            state          <= WB;
          end else begin
            ctrl        <= '0;
            done        <= 1'b1;
            instr_count <= instr_count + COUNT_W'(1);
            state       <= IDLE;
          end
        end
        WB: begin
          ctrl        <= '0;
          done        <= 1'b1;
          instr_count <= instr_count + COUNT_W'(1);
          state       <= IDLE;
        end
        default: begin
          ctrl  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign inst_ready = (state == IDLE);
  assign busy       = ~inst_ready;
  assign RegDst     = ctrl.reg_dst;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrc     = ctrl.alu_src;
  assign ALUctrl    = ctrl.alu_ctrl;
  assign MemWrite   = ctrl.mem_write;
  assign MemRead    = ctrl.mem_read;
  assign MemToReg   = ctrl.mem_to_reg;

endmodule

`default_nettype wire

// File: tb/tb_mips_control_sequencer.sv
// tb_mips_control_sequencer: transaction-timeline model of the sequencer checked
// every cycle, plus directed literal checks and randomized traffic.
`default_nettype none

module tb_mips_control_sequencer;

  localparam int CW = 4;
  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_ILL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   inst_in = '0;
  logic          inst_valid = 1'b0;
  logic          inst_ready, busy, done, illegal;
  logic [31:0]   Inst;
  logic          RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg;
  logic [2:0]    ALUctrl;
  logic [CW-1:0] instr_count;

  mips_control_sequencer #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .Inst(Inst), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .ALUctrl(ALUctrl), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemToReg(MemToReg), .busy(busy), .done(done), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction classification straight from the ISA table.
  task automatic classify(input logic [31:0] w, output int cls, output logic [2:0] alu);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    alu = 3'b010;
    cls = C_ILL;
    if (op == 6'h00) begin
      cls = C_R;
      if (fn == 6'h20) alu = 3'b010;
      else if (fn == 6'h22) alu = 3'b110;
      else if (fn == 6'h24) alu = 3'b000;
      else if (fn == 6'h25) alu = 3'b001;
      else if (fn == 6'h2A) alu = 3'b111;
      else cls = C_ILL;
    end else if (op == 6'h08) cls = C_ADDI;
    else if (op == 6'h23) cls = C_LW;
    else if (op == 6'h2B) cls = C_SW;
  endtask

  function automatic int latency(input int cls);
    case (cls)
      C_LW:    return 5;
      C_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  // Model: k = cycles since accept edge; instruction occupies offsets 1..len, len = done cycle.
  bit            checking = 0;
  bit            active = 0;
  int            k = 0;
  int            m_len = 0;
  int            m_cls = C_ILL;
  logic [2:0]    m_alu = 3'b010;
  logic [31:0]   m_inst = '0;
  logic [CW-1:0] m_count = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      checking = 1;
      active   = 0;
      k        = 0;
      m_inst   = '0;
      m_count  = '0;
    end else if (!active || k == m_len) begin
      if (inst_valid) begin
        m_inst = inst_in;
        classify(m_inst, m_cls, m_alu);
        m_len  = latency(m_cls);
        active = 1;
        k      = 1;
      end else begin
        active = 0;
        k      = 0;
      end
    end else begin
      k++;
      if (k == m_len && m_cls != C_ILL) m_count = m_count + 1'b1;
    end
  end

  always @(negedge clk) begin
    bit idle_now, ctrl_on, writes;
    if (checking) begin
      idle_now = !active || (k == m_len);
      ctrl_on  = active && m_cls != C_ILL && k >= 2 && k <= m_len - 1;
      writes   = (m_cls == C_R || m_cls == C_ADDI || m_cls == C_LW);
      cmp("inst_ready", 32'(inst_ready), 32'(idle_now));
      cmp("busy", 32'(busy), 32'(!idle_now));
      cmp("Inst", Inst, m_inst);
      cmp("done", 32'(done), 32'(active && k == m_len));
      cmp("illegal", 32'(illegal), 32'(active && k == m_len && m_cls == C_ILL));
      cmp("instr_count", 32'(instr_count), 32'(m_count));
      cmp("RegDst", 32'(RegDst), 32'(ctrl_on && m_cls == C_R));
      cmp("ALUSrc", 32'(ALUSrc), 32'(ctrl_on && m_cls != C_R));
      cmp("MemToReg", 32'(MemToReg), 32'(ctrl_on && m_cls == C_LW));
      cmp("ALUctrl", 32'(ALUctrl), ctrl_on ? 32'(m_alu) : 32'd0);
      cmp("RegWrite", 32'(RegWrite), 32'(active && writes && k == m_len - 1));
      cmp("MemRead", 32'(MemRead), 32'(active && m_cls == C_LW && (k == 3 || k == 4)));
      cmp("MemWrite", 32'(MemWrite), 32'(active && m_cls == C_SW && k == 3));
      cmp("wr_exclusive", 32'(RegWrite && MemWrite), 32'd0);
    end
  end

  // Offer an instruction, wait for acceptance and for done; checks latency literally.
  task automatic send(input logic [31:0] w, input int exp_lat, input string name);
    int n, lat;
    inst_in    = w;
    inst_valid = 1'b1;
    n = 0;
    while (!inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) begin
      n_bad++;
      $display("FAIL %s accept timeout: inst_ready %b required 1", name, inst_ready);
    end
    @(negedge clk);
    inst_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    cmp({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    inst_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] b;
    logic [5:0] fns [5];
    int r;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    b = $urandom;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return {6'h00, b[25:6], fns[$urandom_range(0, 4)]};
      4:          return {6'h08, b[25:0]};
      5:          return {6'h23, b[25:0]};
      6:          return {6'h2B, b[25:0]};
      7:          return {6'h00, b[25:0]};
      default:    return b;
    endcase
  endfunction

  initial begin
    logic [31:0] seq [6];
    int acc [6];
    int n;
    seq[0] = 32'h00430820; seq[1] = 32'h00430822; seq[2] = 32'h00430824;
    seq[3] = 32'h00430825; seq[4] = 32'h0043082A; seq[5] = 32'h20410005;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp("reset_ready", 32'(inst_ready), 32'd1);
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_count", 32'(instr_count), 32'd0);
    cmp("reset_inst", Inst, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    send(32'h00430820, 4, "add");
    cmp("count_after_add", 32'(instr_count), 32'd1);
    send(32'h8C040008, 5, "lw");
    send(32'hAC04000C, 4, "sw");
    cmp("count_after_sw", 32'(instr_count), 32'd3);
    send(32'hFC000000, 2, "ill_op");
    cmp("ill_op_flag", 32'(illegal), 32'd1);
    send(32'h00430803, 2, "ill_funct");
    cmp("count_after_ill", 32'(instr_count), 32'd3);
    @(negedge clk);

    // Back-to-back with valid held high.
    pulse_reset();
    inst_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inst_in = seq[i];
      n = 0;
      while (!inst_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      acc[i] = cyc;
      @(negedge clk);
    end
    inst_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 6; i++) cmp("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd4);
    cmp("count_after_b2b", 32'(instr_count), 32'd6);
    @(negedge clk);

    // Reset while lw sits in EXEC.
    pulse_reset();
    inst_in = 32'h8C040008;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    cmp("lw_exec_alusrc", 32'(ALUSrc), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp("abort_regwrite", 32'(RegWrite), 32'd0);
    cmp("abort_memread", 32'(MemRead), 32'd0);
    cmp("abort_done", 32'(done), 32'd0);
    cmp("abort_ready", 32'(inst_ready), 32'd1);
    cmp("abort_count", 32'(instr_count), 32'd0);

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 16; i++) send(32'h00430820, 4, "wrap_add");
    cmp("count_wrap", 32'(instr_count), 32'd0);

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 99) == 0);
      inst_valid = ($urandom_range(0, 2) != 0);
      inst_in    = rand_inst();
    end
    @(negedge clk);
    reset = 1'b0;
    inst_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_control_sequencer.md
# mips_control_sequencer

Multi-cycle control sequencer for the single-cycle MIPS datapath. It accepts one instruction at a time over a valid/ready handshake and latches it into an instruction register that drives the datapath `Inst` input. It decodes opcode/funct and steps the datapath through DECODE/EXEC/MEM/WB. Register-file and SRAM write enables are each asserted for exactly one cycle, and the block reports completion and illegal instructions.

## Interface
- `COUNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_in`  in  32  instruction word offered by the fetch side.
- `inst_valid`  in  1  `inst_in` is valid.
- `inst_ready`  out  1  sequencer can accept; equals (state == IDLE).
- `Inst`  out  32  latched instruction register; connects to datapath `Inst`.
- `RegDst`  out  1  1 = write register `Inst[15:11]`; 0 = write register `Inst[20:16]`.
- `RegWrite`  out  1  register-file write enable.
- `ALUSrc`  out  1  1 = sign-extended immediate; 0 = RD2.
- `ALUctrl`  out  3  ALU operation.
- `MemWrite`  out  1  SRAM write enable.
- `MemRead`  out  1  SRAM read enable.
- `MemToReg`  out  1  1 = write-back from SRAM data; 0 = from ALU.
- `busy`  out  1  equals ~`inst_ready`.
- `done`  out  1  one-cycle pulse when an instruction retires or is rejected.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an unsupported instruction.
- `instr_count`  out  COUNT_W  count of legally retired instructions.

## Operation
- Supported instructions:
  - R-type: opcode 0x00, with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi: opcode 0x08.
  - lw: opcode 0x23.
  - sw: opcode 0x2B.
  - Any other opcode, or an R-type with any other funct, is illegal.
- ALUctrl encoding: add 010, sub 110, and 000, or 001, slt 111. addi, lw and sw use add (010).
- Static controls per class:
  - R-type: RegDst=1, ALUSrc=0, MemToReg=0.
  - addi: RegDst=0, ALUSrc=1, MemToReg=0.
  - lw: RegDst=0, ALUSrc=1, MemToReg=1.
  - sw: ALUSrc=1, RegDst=0, MemToReg=0.
- Outputs are Moore: all controls are registered.
- FSM states: IDLE, DECODE, EXEC, MEM, WB.
  - IDLE: `inst_ready`=1. If `inst_valid`=1, latch `Inst`<=`inst_in` and go to DECODE. Otherwise stay.
  - DECODE: classify `Inst`.
    - Illegal: go to IDLE, pulse `done`+`illegal`, count unchanged, no enables asserted.
    - Legal: load static controls, go to EXEC.
  - EXEC: static controls held so the ALU settles. R-type/addi go to WB; lw/sw go to MEM.
  - MEM: lw drives `MemRead`=1 and goes to WB. sw drives `MemWrite`=1 for this cycle only, then returns to IDLE.
  - WB: `RegWrite`=1 for this cycle only. For lw, `MemRead` stays 1 and `MemToReg`=1. Then go to IDLE.
- Returning to IDLE from WB or sw-MEM: `done` pulses in the first IDLE cycle and `instr_count` increments on the same edge.
- On entering IDLE, all controls are cleared to 0; `Inst` holds its last value.
- `instr_count` wraps from 2^COUNT_W−1 to 0.
- `inst_valid` is ignored while busy; `inst_in` is sampled only in IDLE.

## Timing
- Reset values:
  - state=IDLE, `Inst`=0, all controls 0.
  - `done`=0, `illegal`=0, `instr_count`=0.
  - `inst_ready`=1, `busy`=0.
- Reset asserted mid-instruction:
  - Aborts the instruction; no count increment, no `done`.
  - `RegWrite`/`MemWrite` are 0 in the cycle after the reset edge.
  - Reset has priority over the handshake.
- Latency, counted from the accept edge (IDLE with `inst_valid`=1) to the `done` cycle:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - illegal: 2 cycles.
- Back-to-back: a new instruction may be accepted in the `done` cycle itself (IDLE with valid). Max throughput is one instruction per 4 cycles (R-type).
- `RegWrite` and `MemWrite` are never high in the same cycle. Each is high for at most one cycle per instruction.
- Static controls are stable from EXEC through the last state of the instruction.

## Test plan
- Reset then R-type add ($1=$2+$3, inst 0x00430820): `inst_ready` falls the cycle after accept. EXEC/WB have RegDst=1, ALUSrc=0, ALUctrl=010. `RegWrite` is high exactly one cycle (WB). `done` is high 4 cycles after accept. `instr_count`=1.
- lw $4,8($0) (0x8C040008): `MemRead` high in MEM and WB. `RegWrite` high only in WB with MemToReg=1, RegDst=0, ALUSrc=1. `done` at +5.
- sw $4,12($0) (0xAC04000C): `MemWrite` high one cycle (MEM). `RegWrite` never high. `done` at +4.
- Illegal opcode 0x3F (0xFC000000), then funct 0x03: `done`+`illegal` at +2. No enables asserted. `instr_count` unchanged.
- `inst_valid` held high continuously with add, sub, and, or, slt, addi:
  - Each is accepted only in IDLE; ALUctrl = 010, 110, 000, 001, 111, 010 in order.
  - Five of them (add, sub, and, or, addi) retire at a 4-cycle spacing; slt is also 4 cycles.
  - `instr_count`=6 at the end.
- Reset asserted during the WB-pending EXEC of lw: the next cycle is IDLE with all outputs 0, no `RegWrite`, and `instr_count` unchanged.
- Wrap check: preload by running 2^COUNT_W retirements with COUNT_W=4 (16 instructions); `instr_count` returns to 0.
